dx_unit: RTL and testbench

- Parametrised, sequential successor to the 4-bit combinational decode/execute ALU.
- Adds a WIDTH-bit register file, an instruction valid/ready handshake, a result valid/ready handshake, an immediate load and a multi-cycle multiply.
- Sits between the instruction source (testbench or FSM sequencer) and any result consumer.
- Holds at most one instruction in flight, so there are no data hazards.

---
 rtl/dx_pkg.sv | 22 ++
 rtl/dx_alu_comb.sv | 39 +++
 rtl/dx_unit.sv | 180 ++++++++++++++++++
 tb/tb_dx_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dx_pkg.sv
// Shared opcode and state definitions for the dx_unit decode/execute block.
package dx_pkg;

  localparam logic [3:0] OP_SUB         = 4'd0;
  localparam logic [3:0] OP_ADD         = 4'd1;
  localparam logic [3:0] OP_OR          = 4'd2;
  localparam logic [3:0] OP_AND         = 4'd3;
  localparam logic [3:0] OP_ROR         = 4'd4;
  localparam logic [3:0] OP_ROL         = 4'd5;
  localparam logic [3:0] OP_LT          = 4'd6;
  localparam logic [3:0] OP_EQ          = 4'd7;
  localparam logic [3:0] OP_MUL         = 4'd8;
  localparam logic [3:0] OP_LDI         = 4'd9;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dx_alu_comb.sv
// Single-cycle ALU for every opcode except MUL, which the top module iterates.
module dx_alu_comb
  import dx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // Opcode decode and result select; MUL yields zero here and is not an error
  always_comb begin
    res = ZERO;
    err = 1'b0;
    case (op)
      OP_SUB:  res = a - b;
      OP_ADD:  res = a + b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_ROR:  res = {b[0], b[WIDTH-1:1]};
      OP_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_LT:   res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_MUL:  res = ZERO;
      OP_LDI:  res = imm;
      default: begin
        res = ZERO;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dx_unit.sv
// Sequential decode/execute unit: register file, in/out valid-ready handshakes,
// single-cycle ALU ops and a WIDTH-cycle shift-add multiply.
module dx_unit
  import dx_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_rd,
  output logic             out_err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int               CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] regs_r [NREG];
  state_t           state_r, state_next_s;
  logic [AW-1:0]    rd_r;
  logic [WIDTH-1:0] acc_r, mcand_r, mplier_r;
  logic [CW-1:0]    cnt_r;

  logic [WIDTH-1:0] rs_val_s, rt_val_s, alu_res_s, acc_step_s, wr_data_s;
  logic [AW-1:0]    wr_addr_s;
  logic             alu_err_s, accept_s, is_mul_s, mul_last_s, wr_en_s;

  assign rs_val_s   = regs_r[in_rs];
  assign rt_val_s   = regs_r[in_rt];
  assign dbg_data   = regs_r[dbg_addr];
  assign accept_s   = in_valid && in_ready;
  assign is_mul_s   = (in_op == OP_MUL);
  assign mul_last_s = (state_r == S_EXEC) && (cnt_r == CNT_LAST);
  assign acc_step_s = acc_r + (mplier_r[0] ? mcand_r : ZERO);

  dx_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .op  (in_op),
    .a   (rs_val_s),
    .b   (rt_val_s),
    .imm (in_imm),
    .res (alu_res_s),
    .err (alu_err_s)
  );

  // Input readiness: a pending result only frees the slot when it is consumed
  always_comb begin
    in_ready = 1'b0;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else begin
      case (state_r)
        S_IDLE:  in_ready = 1'b1;
        S_EXEC:  in_ready = 1'b0;
        S_RESP:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = is_mul_s ? S_EXEC : S_RESP;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (mul_last_s) begin
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_RESP: begin
        if (accept_s) begin
          state_next_s = is_mul_s ? S_EXEC : S_RESP;
        end else if (out_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_RESP;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Writeback select: ALU result on accept, final multiply step on leaving EXEC
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = in_rd;
    wr_data_s = alu_res_s;
    if (accept_s && !is_mul_s) begin
      wr_en_s = !alu_err_s;
    end else if (mul_last_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = rd_r;
      wr_data_s = acc_step_s;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= ZERO;
      end
    end else if (wr_en_s) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

  // State register and multiply iterator (one multiplier bit per cycle)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      rd_r     <= {AW{1'b0}};
      acc_r    <= ZERO;
      mcand_r  <= ZERO;
      mplier_r <= ZERO;
      cnt_r    <= {CW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        rd_r     <= in_rd;
        acc_r    <= ZERO;
        mcand_r  <= rs_val_s;
        mplier_r <= rt_val_s;
        cnt_r    <= {CW{1'b0}};
      end else if (state_r == S_EXEC) begin
        acc_r    <= acc_step_s;
        mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
        cnt_r    <= cnt_r + CW'(1);
      end
    end
  end

  // Result registers; held stable until the consumer takes them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= ZERO;
      out_rd    <= {AW{1'b0}};
      out_err   <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid <= 1'b1;
      out_data  <= alu_res_s;
      out_rd    <= in_rd;
      out_err   <= alu_err_s;
    end else if (mul_last_s) begin
      out_valid <= 1'b1;
      out_data  <= acc_step_s;
      out_rd    <= rd_r;
      out_err   <= 1'b0;
    end else if ((state_r == S_RESP) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dx_unit.sv
// Self-checking bench for dx_unit: directed vector table, hand-written corner
// sequences and randomized transactions against an arithmetic reference model.
module tb_dx_unit;
  localparam int WIDTH = 8;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic             in_ready, out_valid, out_err;
  logic [3:0]       in_op = 4'd0;
  logic [AW-1:0]    in_rd = '0, in_rs = '0, in_rt = '0, dbg_addr = '0, out_rd;
  logic [WIDTH-1:0] in_imm = '0, out_data, dbg_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model [NREG];

  typedef struct {
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm;
    logic [7:0] exp;
    logic       err;
  } vec_t;
  vec_t vecs[20];

  dx_unit #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Reference: {err, result} from plain unsigned arithmetic mod 256
  function automatic logic [8:0] ref_op(input logic [3:0] op, input logic [7:0] a, b, imm);
    int unsigned x, y, r;
    logic e;
    x = a; y = b; r = 0; e = 1'b0;
    case (op)
      4'd0: r = (x + 256 - y) % 256;
      4'd1: r = (x + y) % 256;
      4'd2: r = x | y;
      4'd3: r = x & y;
      4'd4: r = (y / 2) + (y % 2) * 128;
      4'd5: r = ((x * 2) % 256) + (x / 128);
      4'd6: r = (x < y) ? 1 : 0;
      4'd7: r = (x == y) ? 1 : 0;
      4'd8: r = (x * y) % 256;
      4'd9: r = imm;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string nm);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1;
      chk($sformatf("%s_r%0d", nm, i), 32'(dbg_data), 32'(model[i]));
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, rs, rt, input logic [7:0] imm);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    in_valid = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] r;
    logic [7:0] exp_d;
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm;
    int cyc, stall;
    logic exec_ok;

    vecs[0]  = '{4'd9,  3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0};
    vecs[1]  = '{4'd9,  3'd2, 3'd0, 3'd0, 8'h07, 8'h07, 1'b0};
    vecs[2]  = '{4'd1,  3'd3, 3'd1, 3'd2, 8'h00, 8'h0C, 1'b0};
    vecs[3]  = '{4'd0,  3'd4, 3'd1, 3'd2, 8'h00, 8'hFE, 1'b0};
    vecs[4]  = '{4'd6,  3'd5, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0};
    vecs[5]  = '{4'd7,  3'd6, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{4'd9,  3'd1, 3'd0, 3'd0, 8'h81, 8'h81, 1'b0};
    vecs[7]  = '{4'd4,  3'd7, 3'd0, 3'd1, 8'h00, 8'hC0, 1'b0};
    vecs[8]  = '{4'd5,  3'd7, 3'd1, 3'd0, 8'h00, 8'h03, 1'b0};
    vecs[9]  = '{4'd9,  3'd1, 3'd0, 3'd0, 8'h13, 8'h13, 1'b0};
    vecs[10] = '{4'd9,  3'd2, 3'd0, 3'd0, 8'h0B, 8'h0B, 1'b0};
    vecs[11] = '{4'd8,  3'd3, 3'd1, 3'd2, 8'h00, 8'hD1, 1'b0};
    vecs[12] = '{4'd12, 3'd4, 3'd1, 3'd2, 8'h55, 8'h00, 1'b1};
    vecs[13] = '{4'd2,  3'd5, 3'd1, 3'd2, 8'h00, 8'h1B, 1'b0};
    vecs[14] = '{4'd3,  3'd6, 3'd1, 3'd2, 8'h00, 8'h03, 1'b0};
    vecs[15] = '{4'd6,  3'd0, 3'd2, 3'd1, 8'h00, 8'h01, 1'b0};
    vecs[16] = '{4'd1,  3'd2, 3'd2, 3'd2, 8'h00, 8'h16, 1'b0};
    vecs[17] = '{4'd8,  3'd0, 3'd3, 3'd3, 8'h00, 8'hA1, 1'b0};
    vecs[18] = '{4'd0,  3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[19] = '{4'd7,  3'd6, 3'd3, 3'd3, 8'h00, 8'h01, 1'b0};

    // Reset: two cycles low
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed table, streamed back-to-back with out_ready held high
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      r = ref_op(vecs[i].op, model[vecs[i].rs], model[vecs[i].rt], vecs[i].imm);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cyc = 1; exec_ok = 1'b1;
      while (!out_valid && cyc < 40) begin
        if (in_ready) exec_ok = 1'b0;
        tick();
        cyc++;
      end
      chk($sformatf("v%0d_latency", i), 32'(cyc), (vecs[i].op == 4'd8) ? 32'd9 : 32'd1);
      if (vecs[i].op == 4'd8) chk($sformatf("v%0d_exec_in_ready_low", i), 32'(exec_ok), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      if (!r[8]) model[vecs[i].rd] = r[7:0];
    end
    tick();
    chk("table_drain_valid", 32'(out_valid), 32'd0);
    check_regs("table");

    // Backpressure: ADD result held 5 cycles while a second instruction waits
    out_ready = 1'b0;
    drive(4'd1, 3'd5, 3'd1, 3'd2, 8'h00);
    r = ref_op(4'd1, model[1], model[2], 8'h00);
    exp_d = r[7:0];
    tick();
    model[5] = exp_d;
    drive(4'd0, 3'd6, 3'd5, 3'd1, 8'h00);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), 32'(out_data), 32'(exp_d));
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    r = ref_op(4'd0, model[5], model[1], 8'h00);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_data", 32'(out_data), 32'(r[7:0]));
    chk("bp_second_rd", 32'(out_rd), 32'd6);
    model[6] = r[7:0];
    tick();
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    check_regs("bp");

    // Reset in the 3rd EXEC cycle of a MUL
    drive(4'd8, 3'd7, 3'd1, 3'd2, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_idle_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    check_regs("midrst");
    for (int k = 0; k < WIDTH + 2; k++) tick();
    chk("midrst_no_late_result", 32'(out_valid), 32'd0);

    // Randomized transactions with random backpressure
    out_ready = 1'b0;
    for (int t = 0; t < 60; t++) begin
      op = 4'($urandom_range(0, 15));
      if (t < 8) op = 4'd9;
      rd = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      rt = 3'($urandom_range(0, 7));
      imm = 8'($urandom_range(0, 255));
      stall = $urandom_range(0, 3);
      r = ref_op(op, model[rs], model[rt], imm);
      drive(op, rd, rs, rt, imm);
      chk($sformatf("rnd%0d_in_ready", t), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
        tick();
        cyc++;
      end
      chk($sformatf("rnd%0d_latency op%0d", t, op), 32'(cyc), (op == 4'd8) ? 32'd9 : 32'd1);
      chk($sformatf("rnd%0d_result op%0d", t, op), {20'd0, out_err, out_rd, out_data},
          {20'd0, r[8], rd, r[7:0]});
      for (int s = 0; s < stall; s++) begin
        tick();
        chk($sformatf("rnd%0d_hold%0d", t, s), {19'd0, out_valid, out_err, out_rd, out_data},
            {19'd0, 1'b1, r[8], rd, r[7:0]});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (!r[8]) model[rd] = r[7:0];
      dbg_addr = rd;
      #1;
      chk($sformatf("rnd%0d_dbg", t), 32'(dbg_data), 32'(model[rd]));
    end
    check_regs("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
